// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions: FSM state encodings, default widths and timeout.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  localparam int WB_DW_DEF      = 32;
  localparam int WB_AW_DEF      = 32;
  localparam int WB_NM_DEF      = 2;
  localparam int WB_TO_W_DEF    = 8;
  localparam int WB_TIMEOUT_DEF = 255;

  function automatic int wb_sel_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NM.
module wb_rr_pick #(
  parameter int NM = 2
) (
  input  logic [NM-1:0]         req,
  input  logic [$clog2(NM)-1:0] last,
  output logic [NM-1:0]         grant,
  output logic [$clog2(NM)-1:0] idx,
  output logic                  valid
);

  localparam int IW = $clog2(NM);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    // Search starts one past the previous owner so it goes to the back of the line
    for (int i = 1; i <= NM; i++) begin
      k = (int'(last) + i) % NM;
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone arbiter: round-robin per bus cycle, CYC-held ownership,
// per-beat slave timeout that returns ERR to the owner and parks the bus until CYC drops.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DW      = WB_DW_DEF,
  parameter int AW      = WB_AW_DEF,
  parameter int NM      = WB_NM_DEF,
  parameter int TO_W    = WB_TO_W_DEF,
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NM-1:0]          i_wbm_cyc,
  input  logic [NM-1:0]          i_wbm_stb,
  input  logic [NM-1:0]          i_wbm_we,
  input  logic [NM*AW-1:0]       i_wbm_adr,
  input  logic [NM*DW-1:0]       i_wbm_dat,
  input  logic [NM*DW/8-1:0]     i_wbm_sel,
  output logic [DW-1:0]          o_wbm_dat,
  output logic [NM-1:0]          o_wbm_ack,
  output logic [NM-1:0]          o_wbm_err,
  output logic                   o_wbs_cyc,
  output logic                   o_wbs_stb,
  output logic                   o_wbs_we,
  output logic [AW-1:0]          o_wbs_adr,
  output logic [DW-1:0]          o_wbs_dat,
  output logic [DW/8-1:0]        o_wbs_sel,
  input  logic [DW-1:0]          i_wbs_dat,
  input  logic                   i_wbs_ack,
  output logic [NM-1:0]          o_grant
);

  localparam int IW = $clog2(NM);
  localparam int SW = wb_sel_w(DW);

  arb_state_t    state, nstate;
  logic [IW-1:0] last_q;
  logic [IW-1:0] gidx_q;
  logic [TO_W-1:0] to_cnt;

  logic [NM-1:0] pick_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic ack_g;
  logic err_g;
  logic timeout_hit;

  wb_rr_pick #(.NM(NM)) u_pick (
    .req   (i_wbm_cyc),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Read data is broadcast; only the routed ACK tells a master the data is for it
  assign o_wbm_dat = i_wbs_dat;
  assign o_wbm_ack = {NM{ack_g}} & o_grant;
  assign o_wbm_err = {NM{err_g}} & o_grant;

  always_comb begin
    nstate      = state;
    o_wbs_cyc   = 1'b0;
    o_wbs_stb   = 1'b0;
    o_wbs_we    = 1'b0;
    o_wbs_adr   = '0;
    o_wbs_dat   = '0;
    o_wbs_sel   = '0;
    ack_g       = 1'b0;
    err_g       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) nstate = ST_OWN;
      end
      ST_OWN: begin
        o_wbs_cyc = i_wbm_cyc[gidx_q];
        o_wbs_stb = i_wbm_cyc[gidx_q] & i_wbm_stb[gidx_q];
        if (i_wbm_cyc[gidx_q]) begin
          o_wbs_we  = i_wbm_we[gidx_q];
          o_wbs_adr = i_wbm_adr[gidx_q*AW +: AW];
          o_wbs_dat = i_wbm_dat[gidx_q*DW +: DW];
          o_wbs_sel = i_wbm_sel[gidx_q*SW +: SW];
        end
        ack_g = i_wbs_ack & o_wbs_cyc;
        // An ACK arriving on the last allowed cycle still completes the beat
        timeout_hit = o_wbs_stb & ~i_wbs_ack & (to_cnt == TO_W'(TIMEOUT - 1));
        err_g       = timeout_hit;
        if (!i_wbm_cyc[gidx_q])  nstate = ST_IDLE;
        else if (timeout_hit)    nstate = ST_ABORT;
      end
      ST_ABORT: begin
        if (!i_wbm_cyc[gidx_q]) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_grant <= '0;
      last_q  <= IW'(NM - 1);
      gidx_q  <= '0;
      to_cnt  <= '0;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && pick_valid) begin
        o_grant <= pick_grant;
        last_q  <= pick_idx;
        gidx_q  <= pick_idx;
      end else if (nstate == ST_IDLE) begin
        o_grant <= '0;
      end
      // Counts consecutive unacked strobe cycles of the current beat
      if (o_wbs_stb && !i_wbs_ack && !timeout_hit) to_cnt <= to_cnt + TO_W'(1);
      else                                         to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: reset, vector table, corner sequences, random vs model.
module tb_wb_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NM   = 2;
  localparam int TO_W = 8;
  localparam int TMO  = 16;
  localparam int SW   = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     cyc, stb, we;
  logic [NM*AW-1:0]  adr;
  logic [NM*DW-1:0]  dat;
  logic [NM*SW-1:0]  sel;
  logic [DW-1:0]     mdat;
  logic [NM-1:0]     mack, merr;
  logic              scyc, sstb, swe;
  logic [AW-1:0]     sadr;
  logic [DW-1:0]     sdat_o;
  logic [SW-1:0]     ssel;
  logic [DW-1:0]     sdat;
  logic              sack;
  logic [NM-1:0]     grant;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DW(DW), .AW(AW), .NM(NM), .TO_W(TO_W), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wbm_cyc(cyc), .i_wbm_stb(stb), .i_wbm_we(we),
    .i_wbm_adr(adr), .i_wbm_dat(dat), .i_wbm_sel(sel),
    .o_wbm_dat(mdat), .o_wbm_ack(mack), .o_wbm_err(merr),
    .o_wbs_cyc(scyc), .o_wbs_stb(sstb), .o_wbs_we(swe),
    .o_wbs_adr(sadr), .o_wbs_dat(sdat_o), .o_wbs_sel(ssel),
    .i_wbs_dat(sdat), .i_wbs_ack(sack), .o_grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NM-1:0] cyc;
    logic          ack;
    logic [NM-1:0] e_grant;
    logic          e_scyc;
    logic [NM-1:0] e_mack;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int k, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] se);
    cyc[k]          = c;
    stb[k]          = s;
    we[k]           = w;
    adr[k*AW +: AW] = a;
    dat[k*DW +: DW] = d;
    sel[k*SW +: SW] = se;
  endtask

  // Reference model state: owner index (-1 none), aborted flag, last owner, unacked run length
  int  m_own, m_lst, m_run;
  bit  m_abrt;

  task automatic model_reset();
    m_own = -1; m_lst = NM - 1; m_run = 0; m_abrt = 0;
  endtask

  initial begin
    logic          on;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [NM-1:0] e_mack, e_err, e_grant;
    logic          err_seen;
    bit            mute;

    vecs[0]  = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[2]  = '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00};
    vecs[3]  = '{2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[4]  = '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
    vecs[5]  = '{2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[6]  = '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[7]  = '{2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
    vecs[8]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[9]  = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
    vecs[10] = '{2'b10, 1'b1, 2'b01, 1'b0, 2'b00};
    vecs[11] = '{2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[12] = '{2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
    vecs[13] = '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

    // Reset held with both masters requesting
    rst_n = 1'b0;
    cyc = 2'b11; stb = 2'b11; we = 2'b11;
    adr = {32'h1111_2222, 32'h3333_4444};
    dat = {32'h5555_6666, 32'h7777_8888};
    sel = 8'hFF;
    sdat = 32'hCAFE_F00D; sack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_scyc",  64'(scyc), 64'd0);
    chk("rst_sstb",  64'(sstb), 64'd0);
    chk("rst_swe",   64'(swe), 64'd0);
    chk("rst_sadr",  64'(sadr), 64'd0);
    chk("rst_sdat",  64'(sdat_o), 64'd0);
    chk("rst_ssel",  64'(ssel), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mack",  64'(mack), 64'd0);
    chk("rst_merr",  64'(merr), 64'd0);
    chk("rst_mdat",  64'(mdat), 64'hCAFE_F00D);
    cyc = '0; stb = '0; we = '0; sack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table: contention, handover dead cycle, rotation, release with late ack
    for (int i = 0; i < 14; i++) begin
      cyc = vecs[i].cyc; stb = vecs[i].cyc; sack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].e_grant));
      chk($sformatf("vec%0d_scyc", i),  64'(scyc),  64'(vecs[i].e_scyc));
      chk($sformatf("vec%0d_mack", i),  64'(mack),  64'(vecs[i].e_mack));
      step();
    end

    // Single master m1 write with two wait states
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF);
    sack = 1'b0;
    @(negedge clk);
    chk("single_idle_scyc", 64'(scyc), 64'd0);
    step();
    @(negedge clk);
    chk("single_adr",   64'(sadr), 64'h1000_0004);
    chk("single_we",    64'(swe), 64'd1);
    chk("single_dat",   64'(sdat_o), 64'hA5A5_5A5A);
    chk("single_grant", 64'(grant), 64'b10);
    chk("single_ws1",   64'(mack), 64'd0);
    step();
    @(negedge clk);
    chk("single_ws2", 64'(mack), 64'd0);
    step();
    sack = 1'b1;
    @(negedge clk);
    chk("single_ack", 64'(mack), 64'b10);
    chk("single_err", 64'(merr), 64'd0);
    step();
    sack = 1'b0; cyc = '0; stb = '0; we = '0;
    @(negedge clk);
    chk("single_drop_scyc", 64'(scyc), 64'd0);
    step();

    // Burst hold: m0 owns four beats while m1 waits
    cyc = 2'b11; stb = 2'b11;
    step();
    sack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      adr[0 +: AW] = 32'h2000_0000 + 32'(b * 4);
      @(negedge clk);
      chk($sformatf("burst%0d_ack", b),   64'(mack), 64'b01);
      chk($sformatf("burst%0d_grant", b), 64'(grant), 64'b01);
      chk($sformatf("burst%0d_adr", b),   64'(sadr), 64'(32'h2000_0000 + 32'(b * 4)));
      step();
    end
    sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    @(negedge clk);
    chk("burst_dead_grant", 64'(grant), 64'd0);
    step();
    @(negedge clk);
    chk("burst_next_grant", 64'(grant), 64'b10);
    step();
    cyc = '0; stb = '0;
    step(); step();

    // Timeout with a slave that never acks
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
    step();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk($sformatf("to_err%0d", i), 64'(merr), (i == TMO - 1) ? 64'b01 : 64'd0);
      step();
    end
    sack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_stb%0d", i), 64'(sstb), 64'd0);
      chk($sformatf("abort_ack%0d", i), 64'(mack), 64'd0);
      chk($sformatf("abort_err%0d", i), 64'(merr), 64'd0);
      step();
    end
    sack = 1'b0; cyc = '0; stb = '0;
    step(); step();

    // Ack lands on the last allowed cycle: ack wins, no err, no abort
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    for (int i = 0; i < TMO - 1; i++) step();
    sack = 1'b1;
    @(negedge clk);
    chk("to_edge_ack", 64'(mack), 64'b01);
    chk("to_edge_err", 64'(merr), 64'd0);
    step();
    sack = 1'b0;
    @(negedge clk);
    chk("to_edge_stb_after", 64'(sstb), 64'd1);
    chk("to_edge_err_after", 64'(merr), 64'd0);
    step();
    cyc = '0; stb = '0;
    step(); step();

    // Stall: CYC held with STB low for 300 cycles
    cyc[0] = 1'b1; stb[0] = 1'b0;
    err_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (merr != '0) err_seen = 1'b1;
      step();
    end
    chk("stall_no_err", 64'(err_seen), 64'd0);
    stb[0] = 1'b1; sack = 1'b1;
    @(negedge clk);
    chk("stall_ack", 64'(mack), 64'b01);
    chk("stall_err", 64'(merr), 64'd0);
    step();

    // Asynchronous reset in the middle of ownership
    sack = 1'b0;
    @(negedge clk);
    chk("midrst_pre_scyc", 64'(scyc), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_scyc",  64'(scyc), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    cyc = '0; stb = '0;
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic against the reference model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      mute = ((n / 80) % 2) == 1;
      for (int k = 0; k < NM; k++) begin
        if ($urandom_range(0, 9) == 0) cyc[k] = ~cyc[k];
        stb[k] = mute ? 1'b1 : 1'($urandom_range(0, 1));
        we[k]  = 1'($urandom_range(0, 1));
        adr[k*AW +: AW] = $urandom;
        dat[k*DW +: DW] = $urandom;
        sel[k*SW +: SW] = 4'($urandom_range(0, 15));
      end
      sack = mute ? 1'b0 : 1'($urandom_range(0, 1));
      sdat = $urandom;

      on      = (m_own >= 0) && !m_abrt;
      e_grant = (m_own >= 0) ? NM'(1 << m_own) : '0;
      e_cyc   = on ? cyc[m_own] : 1'b0;
      e_stb   = on ? (cyc[m_own] & stb[m_own]) : 1'b0;
      e_we    = e_cyc ? we[m_own] : 1'b0;
      e_adr   = e_cyc ? adr[m_own*AW +: AW] : '0;
      e_dat   = e_cyc ? dat[m_own*DW +: DW] : '0;
      e_sel   = e_cyc ? sel[m_own*SW +: SW] : '0;
      e_mack  = (e_cyc && sack) ? NM'(1 << m_own) : '0;
      e_err   = (e_stb && !sack && m_run == TMO - 1) ? NM'(1 << m_own) : '0;

      @(negedge clk);
      chk("rnd_grant", 64'(grant), 64'(e_grant));
      chk("rnd_scyc",  64'(scyc), 64'(e_cyc));
      chk("rnd_sstb",  64'(sstb), 64'(e_stb));
      chk("rnd_swe",   64'(swe), 64'(e_we));
      chk("rnd_sadr",  64'(sadr), 64'(e_adr));
      chk("rnd_sdat",  64'(sdat_o), 64'(e_dat));
      chk("rnd_ssel",  64'(ssel), 64'(e_sel));
      chk("rnd_mack",  64'(mack), 64'(e_mack));
      chk("rnd_merr",  64'(merr), 64'(e_err));
      chk("rnd_mdat",  64'(mdat), 64'(sdat));

      if (m_own < 0) begin
        for (int i = 1; i <= NM; i++) begin
          if (m_own < 0 && cyc[(m_lst + i) % NM]) m_own = (m_lst + i) % NM;
        end
        if (m_own >= 0) m_lst = m_own;
        m_run = 0;
      end else if (m_abrt) begin
        if (!cyc[m_own]) begin
          m_own = -1; m_abrt = 0;
        end
        m_run = 0;
      end else begin
        m_run = (e_stb && !sack && e_err == '0) ? m_run + 1 : 0;
        if (!cyc[m_own])       m_own = -1;
        else if (e_err != '0)  m_abrt = 1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
